button_scan_ctrl: RTL and testbench
===================================

// Module: button_scan_ctrl
// PURPOSE
//  Debounces N_BTN raw push-button inputs with one shared debounce counter, time-shared
//  between buttons by a round-robin arbiter. Holds the debounced level of every button and
//  reports each committed press/release as an event on a valid/ready interface. Sits between
//  the board buttons and the user-interface logic.
// PARAMETERS
//  N_BTN      4       number of button inputs (>=2)
//  ID_W       2       width of event id, >= clog2(N_BTN)
//  DEB_CYCLES 250000  clocks a new level must persist to commit (5 ms @ 50 MHz), >=2
//  CNT_W      18      debounce counter width; must represent DEB_CYCLES-1
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous, active-high reset
//  btn_in     in   N_BTN  raw asynchronous button inputs, active high
//  btn_level  out  N_BTN  debounced stable level per button
//  evt_valid  out  1      event available
//  evt_ready  in   1      consumer accepts event when evt_valid & evt_ready
//  evt_id     out  ID_W   index of button that changed
//  evt_press  out  1      1 = press (0->1), 0 = release (1->0)
//  busy       out  1      high when FSM not in IDLE
// BEHAVIOUR
//  - Reset: sync FFs, btn_level, counter, ptr, sel, evt_id, evt_press, evt_valid all 0; FSM=IDLE.
//  - Each btn_in bit passes a 2-FF synchronizer -> sync[]. mismatch = sync ^ btn_level.
//  - Round-robin pointer ptr (0..N_BTN-1): search mismatch starting at ptr, wrapping.
//  - IDLE: if any mismatch bit set, sel <= first found, counter <= 0, -> COUNT. Else stay.
//  - COUNT: if sync[sel]==btn_level[sel] (bounce back): abort, ptr <= sel+1 mod N, -> IDLE,
//    no event, btn_level unchanged. Else if counter==DEB_CYCLES-1: btn_level[sel] <= sync[sel],
//    evt_id <= sel, evt_press <= sync[sel], evt_valid <= 1, -> EMIT. Else counter++.
//  - EMIT: hold evt_valid/evt_id/evt_press stable until evt_ready; on handshake edge
//    evt_valid <= 0, ptr <= sel+1 mod N, -> IDLE. No new debounce starts while in EMIT.
//  - Latency (controller idle): edge 0 = first edge sampling new btn_in level; btn_level and
//    evt_valid update at edge DEB_CYCLES+2. btn_level changes before event is accepted.
//  - Other buttons changing during COUNT/EMIT stay pending (mismatch persists) and are served
//    later in RR order; a change that reverts before being selected is silently filtered.
//  - Pulse shorter than DEB_CYCLES on selected button -> no event, no level change.
//  - A button toggling again after commit is a fresh mismatch; counted from 0 when selected.
//  - evt_ready while evt_valid low is ignored. ptr wraps N_BTN-1 -> 0.
//  - rst mid-operation: immediate return to reset values; a pending event is dropped. Inputs
//    held high at reset release produce press events after normal debounce.
//  - busy = (FSM != IDLE), combinational from state.
// TESTING (bench uses DEB_CYCLES=8, N_BTN=4)
//  1 btn_in[2] 0->1 held, evt_ready=1 -> btn_level[2]=1 and evt_valid=1, id=2, press=1
//    at edge 10; single-cycle valid; release later -> id=2, press=0.
//  2 btn_in[1] high for 5 cycles then low -> no evt_valid, btn_level stays 0000, FSM back IDLE.
//  3 btn_in[0] and [3] rise same cycle, ptr=0 -> event id=0 first, then id=3; both levels 1.
//  4 evt_ready=0 for 20 cycles after event -> evt_valid/id/press stable; no second event even
//    though btn_in[1] changed; after ready, id=1 event follows after 8 more COUNT cycles.
//  5 Button 0 bouncing continuously while btn_in[2] held -> abort advances ptr, id=2 event
//    issued (no starvation).
//  6 rst asserted mid-COUNT and during EMIT -> next cycle evt_valid=0, btn_level=0, busy=0.

Source files
------------

// File: rtl/button_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : button_scan_ctrl
// Description: Round-robin debouncer sharing one counter across N_BTN buttons;
//              emits press/release events on a valid/ready interface.
// Revision   : 1.0 - initial release
// ============================================================================
module button_scan_ctrl #(
    parameter int N_BTN      = 4,
    parameter int ID_W       = 2,
    parameter int DEB_CYCLES = 250000,
    parameter int CNT_W      = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic             evt_press,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [ID_W-1:0]  c_MAX_ID = ID_W'(N_BTN - 1);

    state_t             state_q, state_d;
    logic [N_BTN-1:0]   sync1_q, sync2_q;
    logic [N_BTN-1:0]   level_q, level_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    sel_q, sel_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               press_q, press_d;
    logic               valid_q, valid_d;

    logic [N_BTN-1:0]   mismatch_w;
    logic [N_BTN-1:0]   rot_w;
    logic [ID_W-1:0]    first_w;
    logic [ID_W-1:0]    sel_next_w;

    assign mismatch_w = sync2_q ^ level_q;
    // Rotating by ptr makes bit 0 the highest-priority candidate.
    assign rot_w      = N_BTN'({mismatch_w, mismatch_w} >> ptr_q);
    assign sel_next_w = (sel_q == c_MAX_ID) ? '0 : sel_q + 1'b1;

    always_comb begin
        logic          found;
        logic [ID_W-1:0] off;
        int            s;
        found = 1'b0;
        off   = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (!found && rot_w[i]) begin
                found = 1'b1;
                off   = ID_W'(i);
            end
        end
        s = int'(ptr_q) + int'(off);
        if (s >= N_BTN) begin
            s = s - N_BTN;
        end
        first_w = ID_W'(s);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            id_q    <= '0;
            press_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            id_q    <= id_d;
            press_q <= press_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        id_d    = id_q;
        press_d = press_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (|mismatch_w) begin
                    sel_d   = first_w;
                    cnt_d   = '0;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (sync2_q[sel_q] == level_q[sel_q]) begin
                    // Bounced back: move on so a noisy button cannot starve others.
                    ptr_d   = sel_next_w;
                    state_d = S_IDLE;
                end else if (cnt_q == c_LAST) begin
                    level_d[sel_q] = sync2_q[sel_q];
                    id_d           = sel_q;
                    press_d        = sync2_q[sel_q];
                    valid_d        = 1'b1;
                    state_d        = S_EMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EMIT: begin
                if (evt_ready) begin
                    valid_d = 1'b0;
                    ptr_d   = sel_next_w;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign btn_level = level_q;
    assign evt_valid = valid_q;
    assign evt_id    = id_q;
    assign evt_press = press_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_button_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_button_scan_ctrl
// Description: Scoreboard bench for button_scan_ctrl (N_BTN=4, DEB_CYCLES=8).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_button_scan_ctrl;

    localparam int N_BTN = 4;
    localparam int ID_W  = 2;

    logic             clk;
    logic             rst;
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic             evt_valid;
    logic             evt_ready;
    logic [ID_W-1:0]  evt_id;
    logic             evt_press;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [ID_W:0] exp_q[$];
    logic [ID_W:0] e;

    button_scan_ctrl #(
        .N_BTN(N_BTN), .ID_W(ID_W), .DEB_CYCLES(8), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_press(evt_press), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: sampled just after the falling edge, i.e. what the next rising edge will see.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_evt: got id=%0d press=%0b expected none", evt_id, evt_press);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_id_press", {29'd0, evt_id, evt_press}, {29'd0, e});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; btn_in = '0; evt_ready = 1'b0;
        step(3);
        chk("rst_level", btn_level, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_idpress", {evt_id, evt_press}, 0);
        rst = 1'b0;
        step(2);

        // 1: press and release of button 2
        btn_in = 4'b0100; evt_ready = 1'b1; exp_q.push_back({2'd2, 1'b1});
        step(10);
        chk("t1_valid_e9", evt_valid, 0);
        chk("t1_level_e9", btn_level, 4'b0000);
        step(1);
        chk("t1_valid_e10", evt_valid, 1);
        chk("t1_level_e10", btn_level, 4'b0100);
        step(1);
        chk("t1_single_valid", evt_valid, 0);
        step(3);
        btn_in = 4'b0000; exp_q.push_back({2'd2, 1'b0});
        step(14);
        chk("t1_release_level", btn_level, 4'b0000);

        // 2: short pulse on button 1
        btn_in = 4'b0010;
        step(5);
        btn_in = 4'b0000;
        step(15);
        chk("t2_level", btn_level, 4'b0000);
        chk("t2_busy", busy, 0);

        // 3: simultaneous rise on 0 and 3 with ptr reset to 0
        rst = 1'b1; step(2); rst = 1'b0; step(1);
        btn_in = 4'b1001; exp_q.push_back({2'd0, 1'b1}); exp_q.push_back({2'd3, 1'b1});
        step(11);
        chk("t3_level_first", btn_level, 4'b0001);
        step(20);
        chk("t3_level_both", btn_level, 4'b1001);

        // 4: back-pressure holds the event, other change stays pending
        evt_ready = 1'b0;
        btn_in = 4'b1000; exp_q.push_back({2'd0, 1'b0});
        step(11);
        btn_in = 4'b1010; exp_q.push_back({2'd1, 1'b1});
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("t4_hold_valid", evt_valid, 1);
            chk("t4_hold_idpress", {evt_id, evt_press}, {2'd0, 1'b0});
        end
        chk("t4_level_early", btn_level, 4'b1000);
        evt_ready = 1'b1;
        step(1);
        chk("t4_valid_drop", evt_valid, 0);
        step(8);
        chk("t4_valid_e8", evt_valid, 0);
        step(1);
        chk("t4_valid_e9", evt_valid, 1);
        chk("t4_level", btn_level, 4'b1010);
        step(2);

        // 5: noisy button 0 must not starve button 2
        btn_in = 4'b0000;
        rst = 1'b1; step(2); rst = 1'b0; step(1);
        btn_in = 4'b0100; exp_q.push_back({2'd2, 1'b1});
        for (int i = 0; i < 20; i++) begin
            btn_in[0] = ~btn_in[0];
            step(3);
        end
        step(20);
        chk("t5_level", btn_level, 4'b0100);
        chk("t5_busy", busy, 0);

        // 6: reset during COUNT and during EMIT
        btn_in = 4'b0101;
        step(5);
        chk("t6_busy_count", busy, 1);
        rst = 1'b1;
        step(1);
        chk("t6a_valid", evt_valid, 0);
        chk("t6a_level", btn_level, 0);
        chk("t6a_busy", busy, 0);
        evt_ready = 1'b0; btn_in = 4'b0001;
        step(2);
        rst = 1'b0;
        step(10);
        chk("t6_valid_e9", evt_valid, 0);
        step(1);
        chk("t6_valid_e10", evt_valid, 1);
        chk("t6_idpress", {evt_id, evt_press}, {2'd0, 1'b1});
        chk("t6_level_e10", btn_level, 4'b0001);
        step(5);
        chk("t6_emit_busy", busy, 1);
        rst = 1'b1; btn_in = 4'b0000;
        step(1);
        chk("t6b_valid", evt_valid, 0);
        chk("t6b_level", btn_level, 0);
        chk("t6b_busy", busy, 0);
        rst = 1'b0; evt_ready = 1'b1;
        step(20);
        chk("t6_quiet_busy", busy, 0);
        chk("t6_quiet_level", btn_level, 0);

        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
